// File: rtl/game_round_controller_if.sv
// Core-facing bundle between the round controller (master) and the memory-game core (slave).
interface game_core_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] D;
    logic [3:0] E;
    logic [3:0] F;
    logic       enable;
    logic       bOut;
    logic       gameTimeout;
    logic       round_done;
    logic       end_game;

    modport master (
        output A, B, C, D, E, F,
        output enable, bOut, gameTimeout,
        input  round_done, end_game
    );

    modport slave (
        input  A, B, C, D, E, F,
        input  enable, bOut, gameTimeout,
        output round_done, end_game
    );
endinterface

// File: rtl/game_round_controller.sv
// Round sequencer for the memory-game core: LFSR index generation, countdown,
// round counting and the timeout/end handshake.
module game_round_controller #(
    parameter int unsigned TICKS_PER_SEC = 50000000,
    parameter int unsigned GAME_SECONDS  = 60,
    parameter int unsigned MAX_ROUNDS    = 9,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    game_core_if.master      core,
    output logic [6:0]       secondsLeft,
    output logic [3:0]       round,
    output logic             busy,
    output logic             won
);

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        ARM,
        PLAY,
        TIMEOUT,
        DONE
    } state_t;

    localparam int unsigned TW = $clog2(TICKS_PER_SEC + 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] tick;
    logic [15:0]   lfsr;
    logic [3:0]    slot_val [6];
    logic [2:0]    slot_idx;

    logic btn_s1, btn_s2, btn_d;
    logic rd_d, eg_d;
    logic btn_rise, rd_rise, eg_rise;
    logic tick_wrap, cand_ok;
    logic start_game, accept, clear_tick, dec_sec, bump_round, win_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_d  <= 1'b0;
            rd_d   <= 1'b0;
            eg_d   <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            btn_d  <= btn_s2;
            rd_d   <= core.round_done;
            eg_d   <= core.end_game;
        end
    end

    assign btn_rise  = btn_s2 & ~btn_d;
    assign rd_rise   = core.round_done & ~rd_d;
    assign eg_rise   = core.end_game & ~eg_d;
    assign tick_wrap = (tick == TW'(TICKS_PER_SEC - 1));

    // Free-running in every state so the indices depend on when the player presses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        cand_ok = (lfsr[3:0] != 4'hF);
        for (int unsigned i = 0; i < 6; i++) begin
            if ((3'(i) < slot_idx) && (slot_val[i] == lfsr[3:0])) begin
                cand_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        core.enable      = 1'b0;
        core.bOut        = 1'b0;
        core.gameTimeout = 1'b0;
        busy             = 1'b1;
        start_game       = 1'b0;
        accept           = 1'b0;
        clear_tick       = 1'b0;
        dec_sec          = 1'b0;
        bump_round       = 1'b0;
        win_hit          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (btn_rise) begin
                    start_game = 1'b1;
                    state_next = GEN;
                end
            end
            GEN: begin
                if (cand_ok) begin
                    accept = 1'b1;
                    if (slot_idx == 3'd5) begin
                        state_next = ARM;
                    end
                end
            end
            ARM: begin
                core.enable = 1'b1;
                core.bOut   = (round == 4'd0);
                clear_tick  = 1'b1;
                state_next  = PLAY;
            end
            PLAY: begin
                core.enable = 1'b1;
                core.bOut   = btn_rise;
                dec_sec     = tick_wrap && (secondsLeft != 7'd0);
                // Timeout takes priority over a coincident round completion.
                if (tick_wrap && (secondsLeft == 7'd1)) begin
                    core.gameTimeout = 1'b1;
                    state_next       = TIMEOUT;
                end else if (rd_rise) begin
                    bump_round = 1'b1;
                    if ((round + 4'd1) == 4'(MAX_ROUNDS)) begin
                        win_hit    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = GEN;
                    end
                end
            end
            TIMEOUT: begin
                core.enable = 1'b1;
                if (eg_rise) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy = 1'b0;
                if (btn_rise) begin
                    start_game = 1'b1;
                    state_next = GEN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 6; i++) begin
                slot_val[i] <= '0;
            end
            slot_idx    <= '0;
            tick        <= '0;
            secondsLeft <= '0;
            round       <= '0;
            won         <= 1'b0;
        end else begin
            if (start_game) begin
                round       <= '0;
                won         <= 1'b0;
                secondsLeft <= 7'(GAME_SECONDS);
                slot_idx    <= '0;
            end
            if (accept) begin
                slot_val[slot_idx] <= lfsr[3:0];
                slot_idx           <= slot_idx + 3'd1;
            end
            if (clear_tick) begin
                tick <= '0;
            end else if (state == PLAY) begin
                tick <= tick_wrap ? '0 : tick + TW'(1);
            end
            if (dec_sec) begin
                secondsLeft <= secondsLeft - 7'd1;
            end
            if (bump_round) begin
                round    <= round + 4'd1;
                slot_idx <= '0;
            end
            if (win_hit) begin
                won <= 1'b1;
            end
        end
    end

    assign core.A = slot_val[0];
    assign core.B = slot_val[1];
    assign core.C = slot_val[2];
    assign core.D = slot_val[3];
    assign core.E = slot_val[4];
    assign core.F = slot_val[5];

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with a short countdown and two-round win.
module tb_game_round_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic [6:0] secondsLeft;
    logic [3:0] round;
    logic       busy;
    logic       won;

    int tests = 0;
    int fails = 0;

    game_core_if core ();

    game_round_controller #(
        .TICKS_PER_SEC(4),
        .GAME_SECONDS (3),
        .MAX_ROUNDS   (2),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .core       (core),
        .secondsLeft(secondsLeft),
        .round      (round),
        .busy       (busy),
        .won        (won)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn();
        btn = 1'b1;
        step(3);
        btn = 1'b0;
    endtask

    task automatic wait_arm(output bit found, output int bad);
        found = 1'b0;
        bad   = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (core.enable === 1'b1) found = 1'b1;
            else begin
                if (core.bOut !== 1'b0) bad++;
                @(negedge clk);
            end
        end
    endtask

    task automatic check_indices(input string tag);
        logic [3:0] v [6];
        bit ok_range;
        bit ok_dist;
        v[0] = core.A; v[1] = core.B; v[2] = core.C;
        v[3] = core.D; v[4] = core.E; v[5] = core.F;
        ok_range = 1'b1;
        ok_dist  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (v[i] > 4'd14) ok_range = 1'b0;
            for (int j = i + 1; j < 6; j++)
                if (v[i] == v[j]) ok_dist = 1'b0;
        end
        check({tag, "_range"}, 32'(ok_range), 32'd1);
        check({tag, "_distinct"}, 32'(ok_dist), 32'd1);
    endtask

    initial begin
        bit found;
        int bad;
        int cnt;

        rst = 1'b0;
        btn = 1'b0;
        core.round_done = 1'b0;
        core.end_game   = 1'b0;
        step(3);
        check("rst_A", 32'(core.A), 32'd0);
        check("rst_F", 32'(core.F), 32'd0);
        check("rst_enable", 32'(core.enable), 32'd0);
        check("rst_bOut", 32'(core.bOut), 32'd0);
        check("rst_timeout", 32'(core.gameTimeout), 32'd0);
        check("rst_secs", 32'(secondsLeft), 32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_won", 32'(won), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr), 32'hACE1);

        rst = 1'b1;
        step(5);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_enable", 32'(core.enable), 32'd0);

        // Game 1: run out the clock.
        press_btn();
        check("gen_busy", 32'(busy), 32'd1);
        check("gen_enable", 32'(core.enable), 32'd0);
        wait_arm(found, bad);
        check("g1_arm_found", 32'(found), 32'd1);
        check("g1_gen_bout", 32'(bad), 32'd0);
        check("g1_arm_bOut", 32'(core.bOut), 32'd1);
        check("g1_arm_round", 32'(round), 32'd0);
        check("g1_arm_secs", 32'(secondsLeft), 32'd3);
        check_indices("g1_idx");
        step(1);
        check("g1_play1_bOut", 32'(core.bOut), 32'd0);
        step(3);
        check("g1_play4_secs", 32'(secondsLeft), 32'd3);
        step(1);
        check("g1_play5_secs", 32'(secondsLeft), 32'd2);
        step(6);
        check("g1_play11_to", 32'(core.gameTimeout), 32'd0);
        check("g1_play11_secs", 32'(secondsLeft), 32'd1);
        step(1);
        check("g1_play12_to", 32'(core.gameTimeout), 32'd1);
        step(1);
        check("g1_tout_to", 32'(core.gameTimeout), 32'd0);
        check("g1_tout_secs", 32'(secondsLeft), 32'd0);
        check("g1_tout_enable", 32'(core.enable), 32'd1);
        check("g1_tout_busy", 32'(busy), 32'd1);

        btn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (core.bOut === 1'b1) cnt++;
        end
        btn = 1'b0;
        step(3);
        check("tout_btn_bOut", 32'(cnt), 32'd0);
        check("tout_hold_enable", 32'(core.enable), 32'd1);

        core.end_game = 1'b1;
        step(1);
        check("g1_done_busy", 32'(busy), 32'd0);
        check("g1_done_enable", 32'(core.enable), 32'd0);
        check("g1_done_secs", 32'(secondsLeft), 32'd0);
        core.end_game = 1'b0;

        // Game 2: two rounds solved, win.
        press_btn();
        wait_arm(found, bad);
        check("g2_arm_found", 32'(found), 32'd1);
        check("g2_arm_bOut", 32'(core.bOut), 32'd1);
        check("g2_arm_secs", 32'(secondsLeft), 32'd3);
        check("g2_arm_won", 32'(won), 32'd0);
        btn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (core.bOut === 1'b1) cnt++;
        end
        check("play_hold_pulses", 32'(cnt), 32'd1);
        core.round_done = 1'b1;
        step(1);
        check("r1_round", 32'(round), 32'd1);
        check("r1_gen_enable", 32'(core.enable), 32'd0);
        check("r1_gen_busy", 32'(busy), 32'd1);
        check("r1_won", 32'(won), 32'd0);
        core.round_done = 1'b0;
        btn = 1'b0;
        step(1);
        btn = 1'b1;
        step(3);
        check("gen_btn_bOut", 32'(core.bOut), 32'd0);
        check("gen_btn_enable", 32'(core.enable), 32'd0);
        btn = 1'b0;
        wait_arm(found, bad);
        check("r2_arm_found", 32'(found), 32'd1);
        check("r2_gen_bout", 32'(bad), 32'd0);
        check("r2_arm_bOut", 32'(core.bOut), 32'd0);
        check("r2_arm_secs", 32'(secondsLeft), 32'd2);
        check_indices("r2_idx");
        step(2);
        core.round_done = 1'b1;
        step(1);
        check("win_round", 32'(round), 32'd2);
        check("win_won", 32'(won), 32'd1);
        check("win_busy", 32'(busy), 32'd0);
        check("win_enable", 32'(core.enable), 32'd0);
        core.round_done = 1'b0;

        // Game 3: round_done coincides with the final second.
        press_btn();
        wait_arm(found, bad);
        check("g3_arm_found", 32'(found), 32'd1);
        check("g3_arm_won", 32'(won), 32'd0);
        check("g3_arm_round", 32'(round), 32'd0);
        step(12);
        check("g3_play12_to", 32'(core.gameTimeout), 32'd1);
        core.round_done = 1'b1;
        step(1);
        check("tie_round", 32'(round), 32'd0);
        check("tie_secs", 32'(secondsLeft), 32'd0);
        check("tie_enable", 32'(core.enable), 32'd1);
        check("tie_busy", 32'(busy), 32'd1);
        core.round_done = 1'b0;
        core.end_game = 1'b1;
        step(1);
        check("g3_done_busy", 32'(busy), 32'd0);
        core.end_game = 1'b0;

        // Game 4: reset while generating indices.
        press_btn();
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (dut.slot_idx === 3'd3) found = 1'b1;
            else step(1);
        end
        check("g4_slot3_found", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_A", 32'(core.A), 32'd0);
        check("arst_C", 32'(core.C), 32'd0);
        check("arst_enable", 32'(core.enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_secs", 32'(secondsLeft), 32'd0);
        check("arst_lfsr", 32'(dut.lfsr), 32'hACE1);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (busy !== 1'b0 || core.enable !== 1'b0 || core.bOut !== 1'b0) cnt++;
        end
        check("post_rst_quiet", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
